// File: rtl/obstacle_renderer.sv
// -----------------------------------------------------------------------------
// obstacle_renderer
//
// Per-frame draw sequencer for one vertical obstacle. It reads the obstacle's
// indexed segment port and turns the returned coordinates into VGA-adapter
// plot writes. Each frame it erases the old segment positions in the
// background colour, pulses the obstacle's move, waits one settle cycle, and
// then draws the new positions in the draw colour.
//
// Frame timeline, where the tick is sampled one edge after E0 and N=SEG_COUNT:
//   busy from E1, erase plots E2..E(N+1), move at E(N+2),
//   draw plots E(N+4)..E(2N+3), done with busy low at E(2N+4).
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   enable         in   permits new frames to start
//   frame_tick     in   one-cycle frame request
//   seg_x / seg_y  in   coordinates of the indexed segment (combinational)
//   seg_idx        out  segment index driven to the obstacle
//   move           out  one-cycle step pulse to the obstacle
//   plot           out  VGA write strobe
//   vga_x / vga_y  out  plot coordinates
//   colour         out  plot colour
//   busy           out  frame in progress
//   done           out  one-cycle end-of-frame pulse
//   overrun_count  out  saturating count of dropped ticks (optional)
//
// Optional feature: define OBS_RENDER_OVERRUN_EN to add overrun_count.
// -----------------------------------------------------------------------------
module obstacle_renderer #(
   parameter int          SEG_COUNT   = 10,
   parameter int          IDX_W       = 4,
   parameter logic [2:0]  DRAW_COLOUR = 3'b100,
   parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             frame_tick,
   input  logic [7:0]       seg_x,
   input  logic [6:0]       seg_y,
   output logic [IDX_W-1:0] seg_idx,
   output logic             move,
   output logic             plot,
   output logic [7:0]       vga_x,
   output logic [6:0]       vga_y,
   output logic [2:0]       colour,
   output logic             busy,
   output logic             done
`ifdef OBS_RENDER_OVERRUN_EN
   ,
   output logic [7:0]       overrun_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_MOVE,
      S_SETTLE,
      S_DRAW,
      S_DONE
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEG_COUNT - 1);

   state_e           state_q;
   logic             pending_q;
   logic [IDX_W-1:0] seg_idx_q;
   logic             move_q;
   logic             plot_q;
   logic [7:0]       vga_x_q;
   logic [6:0]       vga_y_q;
   logic [2:0]       colour_q;
   logic             busy_q;
   logic             done_q;
`ifdef OBS_RENDER_OVERRUN_EN
   logic [7:0]       overrun_q;
`endif

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values; later assignments in this block
   // override the defaults written above them.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pending_q <= 1'b0;
         seg_idx_q <= '0;
         move_q    <= 1'b0;
         plot_q    <= 1'b0;
         vga_x_q   <= '0;
         vga_y_q   <= '0;
         colour_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef OBS_RENDER_OVERRUN_EN
         overrun_q <= '0;
`endif
      end else begin
         move_q <= 1'b0;
         done_q <= 1'b0;

         // One-deep request memory: ticks during a frame (including its DONE
         // cycle) queue one more frame; disabling drops any queued request.
         if (!enable) begin
            pending_q <= 1'b0;
         end else if (frame_tick && state_q != S_IDLE) begin
            pending_q <= 1'b1;
         end

`ifdef OBS_RENDER_OVERRUN_EN
         if (frame_tick && pending_q && state_q != S_IDLE && overrun_q != 8'hFF) begin
            overrun_q <= overrun_q + 8'd1;
         end
`endif

         case (state_q)
            S_IDLE: begin
               if ((frame_tick || pending_q) && enable) begin
                  state_q   <= S_ERASE;
                  seg_idx_q <= '0;
                  busy_q    <= 1'b1;
                  pending_q <= 1'b0;
               end
            end

            // Erase and draw share the read/plot path; seg_x/seg_y belong to
            // the index presented during this cycle.
            S_ERASE, S_DRAW: begin
               vga_x_q  <= seg_x;
               vga_y_q  <= seg_y;
               colour_q <= (state_q == S_ERASE) ? BG_COLOUR : DRAW_COLOUR;
               plot_q   <= 1'b1;
               if (seg_idx_q == LAST_IDX) begin
                  seg_idx_q <= '0;
                  state_q   <= (state_q == S_ERASE) ? S_MOVE : S_DONE;
               end else begin
                  seg_idx_q <= seg_idx_q + IDX_W'(1);
               end
            end

            S_MOVE: begin
               plot_q  <= 1'b0;
               move_q  <= 1'b1;
               state_q <= S_SETTLE;
            end

            // Gives the obstacle one edge to register its new positions
            // before the draw pass reads them.
            S_SETTLE: begin
               seg_idx_q <= '0;
               state_q   <= S_DRAW;
            end

            S_DONE: begin
               plot_q  <= 1'b0;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign seg_idx = seg_idx_q;
   assign move    = move_q;
   assign plot    = plot_q;
   assign vga_x   = vga_x_q;
   assign vga_y   = vga_y_q;
   assign colour  = colour_q;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef OBS_RENDER_OVERRUN_EN
   assign overrun_count = overrun_q;
`endif

endmodule

// File: tb/tb_obstacle_renderer.sv
// -----------------------------------------------------------------------------
// tb_obstacle_renderer
//
// Scoreboard bench for obstacle_renderer. Stimulus pushes the expected plot,
// move and done events (with their cycle numbers) into a queue; a monitor on
// the falling clock edge pops and compares whenever the DUT presents one.
// A stub obstacle returns x=40, y=offset+index, where offset steps on move.
// -----------------------------------------------------------------------------
module tb_obstacle_renderer;

   localparam int N = 10;

   typedef enum int { EV_PLOT, EV_MOVE, EV_DONE } ev_kind_e;

   typedef struct {
      ev_kind_e   kind;
      int         cyc;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] col;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       frame_tick;
   logic [7:0] seg_x;
   logic [6:0] seg_y;
   logic [3:0] seg_idx;
   logic       move;
   logic       plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       busy;
   logic       done;
`ifdef OBS_RENDER_OVERRUN_EN
   logic [7:0] overrun_count;
`endif

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  move_cnt = 0;
   int  plot_cnt = 0;
   int  busy_cnt = 0;
   int  y_off_model = 0;
   ev_t sb[$];

   obstacle_renderer dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .frame_tick   (frame_tick),
      .seg_x        (seg_x),
      .seg_y        (seg_y),
      .seg_idx      (seg_idx),
      .move         (move),
      .plot         (plot),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .colour       (colour),
      .busy         (busy),
      .done         (done)
`ifdef OBS_RENDER_OVERRUN_EN
      ,
      .overrun_count(overrun_count)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Stub obstacle: positions step by one row on every move pulse.
   logic [6:0] y_off_hw = 7'd0;
   always @(posedge clock) if (move) y_off_hw <= y_off_hw + 7'd1;
   assign seg_x = 8'd40;
   assign seg_y = y_off_hw + 7'(seg_idx);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input ev_kind_e k, input int c, input logic [6:0] y, input logic [2:0] col);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.x    = 8'd40;
      e.y    = y;
      e.col  = col;
      sb.push_back(e);
   endtask

   // Full expected frame for a tick driven in cycle t.
   task automatic push_frame(input int t);
      for (int i = 0; i < N; i++) push_ev(EV_PLOT, t + 2 + i, 7'(y_off_model + i), 3'b000);
      push_ev(EV_MOVE, t + N + 2, 7'd0, 3'b000);
      for (int i = 0; i < N; i++) push_ev(EV_PLOT, t + N + 4 + i, 7'(y_off_model + 1 + i), 3'b100);
      push_ev(EV_DONE, t + 2 * N + 4, 7'd0, 3'b000);
      y_off_model++;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      @(posedge clock);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_seg_idx"}, 32'(seg_idx), 32'd0);
      check({tag, "_plot"},    32'(plot),    32'd0);
      check({tag, "_move"},    32'(move),    32'd0);
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_done"},    32'(done),    32'd0);
      check({tag, "_vga_x"},   32'(vga_x),   32'd0);
      check({tag, "_vga_y"},   32'(vga_y),   32'd0);
      check({tag, "_colour"},  32'(colour),  32'd0);
   endtask

   // Monitor: compares every presented event against the scoreboard.
   always @(negedge clock) begin
      ev_t      e;
      ev_kind_e k;
      if (busy) busy_cnt++;
      if (seg_idx > 4'd9) check("seg_idx_range", 32'(seg_idx), 32'd9);
      if (plot || move || done) begin
         k = plot ? EV_PLOT : (move ? EV_MOVE : EV_DONE);
         if (move) move_cnt++;
         if (plot) plot_cnt++;
         check("single_event", 32'(int'(plot) + int'(move) + int'(done)), 32'd1);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
         end else begin
            e = sb.pop_front();
            check("ev_kind", 32'(k), 32'(e.kind));
            check("ev_cycle", 32'(cyc), 32'(e.cyc));
            if (k == EV_PLOT) begin
               check("plot_x", 32'(vga_x), 32'(e.x));
               check("plot_y", 32'(vga_y), 32'(e.y));
               check("plot_colour", 32'(colour), 32'(e.col));
            end
         end
      end
   end

   initial begin
      int t;
      int m0;
      int p0;
      int b0;

      reset      = 1'b1;
      enable     = 1'b0;
      frame_tick = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;

      // Single frame.
      enable = 1'b1;
      wait_to(cyc + 2);
      t  = cyc;
      b0 = busy_cnt;
      m0 = move_cnt;
      push_frame(t);
      check("pre_tick_busy", 32'(busy), 32'd0);
      pulse_tick();
      check("busy_rise", 32'(busy), 32'd1);
      wait_to(t + 2 * N + 4);
      check("frame_end_busy", 32'(busy), 32'd0);
      wait_to(t + 30);
      check("single_busy_cycles", 32'(busy_cnt - b0), 32'd23);
      check("single_moves", 32'(move_cnt - m0), 32'd1);

      // Back-to-back: second tick queues, starts right after done.
      t  = cyc;
      m0 = move_cnt;
      push_frame(t);
      push_frame(t + 24);
      pulse_tick();
      wait_to(t + 5);
      pulse_tick();
      wait_to(t + 24);
      check("b2b_gap_busy", 32'(busy), 32'd0);
      wait_to(t + 25);
      check("b2b_second_busy", 32'(busy), 32'd1);
      wait_to(t + 60);
      check("b2b_moves", 32'(move_cnt - m0), 32'd2);

      // Overrun: third tick is dropped.
      t  = cyc;
      m0 = move_cnt;
      p0 = plot_cnt;
      push_frame(t);
      push_frame(t + 24);
      pulse_tick();
      wait_to(t + 3);
      pulse_tick();
      wait_to(t + 6);
      pulse_tick();
      wait_to(t + 80);
      check("overrun_moves", 32'(move_cnt - m0), 32'd2);
      check("overrun_plots", 32'(plot_cnt - p0), 32'd40);
`ifdef OBS_RENDER_OVERRUN_EN
      check("overrun_count", 32'(overrun_count), 32'd1);
`endif

      // Enable low: ticks ignored, and nothing is remembered.
      enable = 1'b0;
      b0 = busy_cnt;
      p0 = plot_cnt;
      pulse_tick();
      repeat (50) @(posedge clock);
      #1;
      check("en_low_busy", 32'(busy_cnt - b0), 32'd0);
      check("en_low_plots", 32'(plot_cnt - p0), 32'd0);
      enable = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      check("en_high_no_tick_busy", 32'(busy_cnt - b0), 32'd0);

      // Enable dropped mid-frame: the frame still completes.
      t  = cyc;
      m0 = move_cnt;
      p0 = plot_cnt;
      push_frame(t);
      pulse_tick();
      wait_to(t + 5);
      enable = 1'b0;
      wait_to(t + 30);
      check("en_drop_plots", 32'(plot_cnt - p0), 32'd20);
      check("en_drop_moves", 32'(move_cnt - m0), 32'd1);
      b0 = busy_cnt;
      wait_to(t + 60);
      check("en_drop_then_idle", 32'(busy_cnt - b0), 32'd0);
      enable = 1'b1;

      // Mid-frame reset: only erase plots 0..6 appear, no move.
      t  = cyc;
      m0 = move_cnt;
      for (int i = 0; i < 7; i++) push_ev(EV_PLOT, t + 2 + i, 7'(y_off_model + i), 3'b000);
      pulse_tick();
      wait_to(t + 8);
      reset = 1'b1;
      wait_to(t + 9);
      check_idle_outputs("midreset");
      wait_to(t + 10);
      reset = 1'b0;
      wait_to(t + 40);
      check("midreset_moves", 32'(move_cnt - m0), 32'd0);

      // Clean frame after the reset.
      t  = cyc;
      b0 = busy_cnt;
      push_frame(t);
      pulse_tick();
      wait_to(t + 2 * N + 4);
      check("post_reset_done", 32'(done), 32'd1);
      wait_to(t + 30);
      check("post_reset_busy_cycles", 32'(busy_cnt - b0), 32'd23);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
